// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state type and op classification for the multi-cycle ALU.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_PASS  = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_SLTU  = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd11;
  localparam logic [3:0] ALU_MULHU = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;
  localparam logic [3:0] ALU_REMU  = 4'd14;
  localparam logic [3:0] ALU_RSVD  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter_op(input logic [3:0] sel);
    return (sel == ALU_MUL) || (sel == ALU_MULHU) || (sel == ALU_DIVU) || (sel == ALU_REMU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// One-bit-per-step shift-add multiplier / restoring divider over a 2*XLEN {hi,lo} register.
module iter_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] lo_o,
  output logic [XLEN-1:0] hi_o
);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
  logic            div_q;
  logic [XLEN:0]   sum, acc, rem_sh;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    sum    = {1'b0, hi_q} + {1'b0, b_q};
    acc    = lo_q[0] ? sum : {1'b0, hi_q};
    rem_sh = {hi_q, lo_q[XLEN-1]};
    if (start_i) begin
      hi_d = '0;
      lo_d = a_i;
    end else if (step_i) begin
      if (div_q) begin
        // b==0 always "fits", giving all-ones quotient and remainder = dividend
        if (rem_sh >= {1'b0, b_q}) begin
          hi_d = XLEN'(rem_sh - {1'b0, b_q});
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {acc, lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (start_i) begin
        b_q   <= b_i;
        div_q <= is_div_i;
      end
    end
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: rtl/alu_mc_module.sv
// RV32 execute-stage ALU: single-cycle ops registered in IDLE/DONE, MUL/DIV iterate in ITER.
module alu_mc_module
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [3:0]      alu_sel,
  output logic            out_valid,
  output logic [XLEN-1:0] res,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d, alu_res, it_lo, it_hi, it_res;
  logic            zero_q, zero_d, vld_q, vld_d, it_zero_q, it_zero_d;
  logic [3:0]      it_sel_q, it_sel_d;
  logic            accept, start, step;
  logic [SHW-1:0]  shamt;

  assign shamt  = op2[SHW-1:0];
  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_PASS: alu_res = op2;
      ALU_AND:  alu_res = op1 & op2;
      ALU_OR:   alu_res = op1 | op2;
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SRL:  alu_res = op1 >> shamt;
      ALU_SRA:  alu_res = $signed(op1) >>> shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      default:  alu_res = '0;
    endcase
  end

  iter_muldiv #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .step_i   (step),
    .is_div_i ((alu_sel == ALU_DIVU) || (alu_sel == ALU_REMU)),
    .a_i      (op1),
    .b_i      (op2),
    .lo_o     (it_lo),
    .hi_o     (it_hi)
  );

  assign it_res = ((it_sel_q == ALU_MULHU) || (it_sel_q == ALU_REMU)) ? it_hi : it_lo;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    zero_d    = zero_q;
    vld_d     = 1'b0;
    it_zero_d = it_zero_q;
    it_sel_d  = it_sel_q;
    start     = 1'b0;
    step      = 1'b0;
    case (state_q)
      ITER: begin
        step = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        // commit the iterative result so res holds it after the DONE pulse
        res_d   = it_res;
        zero_d  = it_zero_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (is_iter_op(alu_sel)) begin
        start     = 1'b1;
        cnt_d     = '1;
        state_d   = ITER;
        it_sel_d  = alu_sel;
        it_zero_d = (op1 == op2);
      end else begin
        res_d  = alu_res;
        zero_d = (op1 == op2);
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      vld_q     <= 1'b0;
      it_zero_q <= 1'b0;
      it_sel_q  <= ALU_ADD;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      vld_q     <= vld_d;
      it_zero_q <= it_zero_d;
      it_sel_q  <= it_sel_d;
    end
  end

  assign in_ready  = (state_q != ITER);
  assign busy      = (state_q == ITER);
  assign out_valid = vld_q || (state_q == DONE);
  assign res       = (state_q == DONE) ? it_res : res_q;
  assign zero      = (state_q == DONE) ? it_zero_q : zero_q;

endmodule

// File: tb/tb_alu_mc_module.sv
// Directed bench for alu_mc_module: vector table for single-cycle ops plus iterative sequences.
module tb_alu_mc_module;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] op1 = '0, op2 = '0, res;
  logic [3:0]  alu_sel = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t sv[15];
  vec_t iv[7];

  alu_mc_module #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .res       (res),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_iter(input vec_t v, input int idx);
    int edges;
    int lowcnt;
    @(negedge clk);
    alu_sel  = v.sel;
    op1      = v.a;
    op2      = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges  = 0;
    lowcnt = (!in_ready) ? 1 : 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (!in_ready) lowcnt++;
    end
    check($sformatf("iter%0d latency", idx), edges, 32);
    check($sformatf("iter%0d ready_low", idx), lowcnt, 32);
    check($sformatf("iter%0d res", idx), res, v.r);
    check($sformatf("iter%0d zero", idx), {31'b0, zero}, {31'b0, v.z});
    @(posedge clk);
    #1;
    check($sformatf("iter%0d single_pulse", idx), {31'b0, out_valid}, 32'd0);
    check($sformatf("iter%0d res_hold", idx), res, v.r);
  endtask

  initial begin
    int pulses;
    sv[0]  = '{ALU_ADD,  32'd6,        32'd5,        32'd11,       1'b0};
    sv[1]  = '{ALU_SUB,  32'd5,        32'd5,        32'd0,        1'b1};
    sv[2]  = '{ALU_PASS, 32'd1,        32'h1234,     32'h1234,     1'b0};
    sv[3]  = '{ALU_AND,  32'hF0F0,     32'hFF00,     32'hF000,     1'b0};
    sv[4]  = '{ALU_OR,   32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0};
    sv[5]  = '{ALU_XOR,  32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0};
    sv[6]  = '{ALU_SLL,  32'd1,        32'h21,       32'd2,        1'b0};
    sv[7]  = '{ALU_SRL,  32'h80000000, 32'd31,       32'd1,        1'b0};
    sv[8]  = '{ALU_SRA,  32'h80000000, 32'h24,       32'hF8000000, 1'b0};
    sv[9]  = '{ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    sv[10] = '{ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    sv[11] = '{ALU_SLT,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    sv[12] = '{ALU_RSVD, 32'd3,        32'd3,        32'd0,        1'b1};
    sv[13] = '{ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    sv[14] = '{ALU_SUB,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};

    iv[0] = '{ALU_MUL,   32'hFFFFFFFF, 32'd2,    32'hFFFFFFFE, 1'b0};
    iv[1] = '{ALU_MULHU, 32'hFFFFFFFF, 32'd2,    32'd1,        1'b0};
    iv[2] = '{ALU_MUL,   32'd12345,    32'd6789, 32'h04FED79D, 1'b0};
    iv[3] = '{ALU_DIVU,  32'd100,      32'd7,    32'd14,       1'b0};
    iv[4] = '{ALU_REMU,  32'd100,      32'd7,    32'd2,        1'b0};
    iv[5] = '{ALU_DIVU,  32'd7,        32'd0,    32'hFFFFFFFF, 1'b0};
    iv[6] = '{ALU_REMU,  32'd7,        32'd0,    32'd7,        1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst res", res, 32'd0);
    check("rst zero", {31'b0, zero}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single-cycle ops, issued back-to-back
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      alu_sel  = sv[i].sel;
      op1      = sv[i].a;
      op2      = sv[i].b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d res", i), res, sv[i].r);
      check($sformatf("vec%0d zero", i), {31'b0, zero}, {31'b0, sv[i].z});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle out_valid", {31'b0, out_valid}, 32'd0);
    check("idle res_hold", res, 32'hFFFFFFFF);

    for (int i = 0; i < 7; i++) run_iter(iv[i], i);

    // ADD held during ITER is ignored, then accepted in DONE
    @(negedge clk);
    alu_sel = ALU_MUL; op1 = 32'd3; op2 = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    alu_sel = ALU_ADD; op1 = 32'd20; op2 = 32'd22;
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("hold latency", n, 32);
    end
    check("hold mul res", res, 32'd12);
    check("hold busy_in_done", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("hold add valid", {31'b0, out_valid}, 32'd1);
    check("hold add res", res, 32'd42);
    check("hold add ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold add pulse", {31'b0, out_valid}, 32'd0);

    // reset during DIVU with cnt==10 aborts it
    @(negedge clk);
    alu_sel = ALU_DIVU; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check("abort busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    check("abort res", res, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("abort late_pulse", pulses, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
